mem_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port WIDTH x DEPTH memory (valid/wr_rd/ready handshake) among N requesters.

---
 rtl/mem_rr_arbiter_pkg.sv | 13 +
 rtl/mem_rr_arbiter_if.sv | 30 +++
 rtl/mem_rr_arbiter_rr_pick.sv | 21 ++
 rtl/mem_rr_arbiter.sv | 63 ++++++
 tb/tb_mem_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// mem_arb_pkg: shared defaults and FSM state encoding for the memory round-robin arbiter
package mem_arb_pkg;
  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 64;
  localparam int TIMEOUT_DEF = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side signals of the arbiter
interface mem_rr_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH_DEF)
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_wr_rd_i;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ*WIDTH-1:0]      req_wdata_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [WIDTH-1:0]            rdata_o;
  logic                        err_o;
  logic                        mem_valid_o;
  logic                        mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0]       mem_addr_o;
  logic [WIDTH-1:0]            mem_wdata_o;
  logic [WIDTH-1:0]            mem_rdata_i;
  logic                        mem_ready_i;
  modport master (
    input  req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_ready_i,
    output req_ready_o, rdata_o, err_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o
  );
  modport slave (
    output req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_ready_i,
    input  req_ready_o, rdata_o, err_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: first pending request scanning upward from the one after the last grant
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any_req
);
  localparam int GW = $clog2(N_REQ);
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!any_req && req[(int'(last) + i) % N_REQ]) begin
        grant   = GW'((int'(last) + i) % N_REQ);
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-port memory among N_REQ requesters, with watchdog abort
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_rr_arbiter_if.master bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  state_t          state, state_n;
  logic [GW-1:0]   grant, last_grant, pick;
  logic [CW-1:0]   cnt;
  logic            any_req, start, tmo, done;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req_valid_i),
    .last    (last_grant),
    .grant   (pick),
    .any_req (any_req)
  );
  always_comb begin
    start   = state == IDLE && any_req;
    tmo     = cnt == CW'(TIMEOUT - 1);
    done    = state == WAIT && (bus.mem_ready_i || tmo);
    state_n = start ? ISSUE : state == ISSUE ? WAIT : done ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      grant           <= '0;
      last_grant      <= GW'(N_REQ - 1);
      cnt             <= '0;
      bus.req_ready_o <= '0;
      bus.rdata_o     <= '0;
      bus.err_o       <= 1'b0;
      bus.mem_valid_o <= 1'b0;
      bus.mem_wr_rd_o <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      state           <= state_n;
      bus.mem_valid_o <= start;
      if (start) begin
        grant           <= pick;
        bus.mem_wr_rd_o <= bus.req_wr_rd_i[pick];
        bus.mem_addr_o  <= bus.req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata_o <= bus.req_wdata_i[int'(pick)*WIDTH +: WIDTH];
      end
      cnt             <= state == ISSUE || tmo ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      // response fields live only during RESP and fall back to zero afterwards
      bus.req_ready_o <= done ? N_REQ'(1) << grant : '0;
      bus.rdata_o     <= done && bus.mem_ready_i && !bus.mem_wr_rd_o ? bus.mem_rdata_i : '0;
      bus.err_o       <= done && !bus.mem_ready_i;
      if (state == RESP) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed and randomized checks of mem_rr_arbiter against a memory model and a grant/data scoreboard
module tb_mem_rr_arbiter;
  localparam int N = 4, W = 16, D = 64, AW = 6, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  mem_rr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  // memory: ready and read data one cycle after the valid pulse, cleared by the shared reset
  logic [W-1:0] mem [D];
  logic stall = 1'b0;
  int vcnt = 0;
  always @(posedge clk) begin
    vcnt <= vcnt + int'(bus.mem_valid_o);
    if (rst) begin
      bus.mem_ready_i <= 1'b0;
      bus.mem_rdata_i <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      bus.mem_ready_i <= bus.mem_valid_o && !stall;
      bus.mem_rdata_i <= '0;
      if (bus.mem_valid_o && !stall) begin
        if (bus.mem_wr_rd_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        else bus.mem_rdata_i <= mem[bus.mem_addr_o];
      end
    end
  end
  int vec = 0, bad = 0;
  logic [W-1:0] ref_mem [D];
  int m_last;
  logic [N-1:0] pend;
  bit p_wr [N];
  int p_addr [N];
  logic [W-1:0] p_data [N];
  function automatic int model_pick();
    for (int i = 1; i <= N; i++) if (pend[(m_last + i) % N]) return (m_last + i) % N;
    return 0;
  endfunction
  function automatic logic [W-1:0] model_resp(int k);
    return p_wr[k] ? '0 : ref_mem[p_addr[k]];
  endfunction
  function automatic void model_commit(int k);
    if (p_wr[k]) ref_mem[p_addr[k]] = p_data[k];
    m_last = k;
  endfunction
  task automatic set_req(int k, bit wr, int addr, logic [W-1:0] data);
    p_wr[k] = wr;
    p_addr[k] = addr;
    p_data[k] = data;
    pend[k] = 1'b1;
    bus.req_valid_i[k] = 1'b1;
    bus.req_wr_rd_i[k] = wr;
    bus.req_addr_i[k*AW +: AW] = AW'(addr);
    bus.req_wdata_i[k*W +: W] = data;
  endtask
  task automatic clr_req(int k);
    pend[k] = 1'b0;
    bus.req_valid_i[k] = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    pend = '0;
    bus.req_valid_i = '0;
    bus.req_wr_rd_i = '0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
  endtask
  task automatic wait_ready(input int budget, output int cyc, output logic [N-1:0] rdy, output logic [W-1:0] rd, output logic er);
    cyc = -1;
    rdy = '0;
    rd = '0;
    er = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0) begin
        cyc = i;
        rdy = bus.req_ready_o;
        rd = bus.rdata_o;
        er = bus.err_o;
        break;
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    vec++; if ({bus.req_ready_o, bus.rdata_o, bus.err_o, bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {bus.req_ready_o, bus.rdata_o, bus.err_o, bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o}); end
    repeat (3) begin
      @(negedge clk);
      vec++; if (bus.mem_valid_o !== 1'b0) begin bad++; $display("FAIL idle_no_valid: got %b want 0", bus.mem_valid_o); end
    end
  endtask
  task automatic test_write_read();
    int cyc; logic [N-1:0] rdy; logic [W-1:0] rd; logic er;
    set_req(0, 1'b1, 5, 16'hBEEF);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (cyc !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", cyc); end
    vec++; if (rdy !== 4'b0001) begin bad++; $display("FAIL wr_ready: got %b want 0001", rdy); end
    vec++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", er); end
    model_commit(0); clr_req(0); @(negedge clk);
    set_req(0, 1'b0, 5, '0);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (cyc !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    vec++; if (rdy !== 4'b0001) begin bad++; $display("FAIL rd_ready: got %b want 0001", rdy); end
    vec++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", rd); end
    vec++; if (er !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", er); end
    model_commit(0); clr_req(0); @(negedge clk);
  endtask
  task automatic test_all_four();
    int cyc; logic [N-1:0] rdy; logic [W-1:0] rd; logic er;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, int'($urandom_range(0, D - 1)), '0);
    for (int n = 0; n < N; n++) begin
      wait_ready(10, cyc, rdy, rd, er);
      vec++; if (rdy !== 4'(1 << n)) begin bad++; $display("FAIL all4_order: got %b want %b", rdy, 4'(1 << n)); end
      vec++; if (cyc !== (n == 0 ? 3 : 4)) begin bad++; $display("FAIL all4_spacing: got %0d want %0d", cyc, n == 0 ? 3 : 4); end
      vec++; if ({er, rd} !== '0) begin bad++; $display("FAIL all4_data: got err %b data %h want 0 0", er, rd); end
      model_commit(n); clr_req(n);
    end
    @(negedge clk);
  endtask
  task automatic test_alternate();
    int cyc, e; logic [N-1:0] rdy; logic [W-1:0] rd; logic er;
    set_req(1, 1'b0, 2, '0);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (rdy !== 4'b0010) begin bad++; $display("FAIL alt_setup: got %b want 0010", rdy); end
    model_commit(1); clr_req(1); @(negedge clk);
    set_req(1, 1'b0, int'($urandom_range(0, D - 1)), '0);
    set_req(3, 1'b0, int'($urandom_range(0, D - 1)), '0);
    for (int n = 0; n < 4; n++) begin
      e = n % 2 == 0 ? 3 : 1;
      wait_ready(10, cyc, rdy, rd, er);
      vec++; if (rdy !== 4'(1 << e)) begin bad++; $display("FAIL alt_grant%0d: got %b want %b", n, rdy, 4'(1 << e)); end
      vec++; if (cyc !== (n == 0 ? 3 : 4)) begin bad++; $display("FAIL alt_spacing%0d: got %0d want %0d", n, cyc, n == 0 ? 3 : 4); end
      model_commit(e);
    end
    clr_req(1); clr_req(3); @(negedge clk);
  endtask
  task automatic test_timeout();
    int cyc; logic [N-1:0] rdy; logic [W-1:0] rd; logic er; logic [W-1:0] d;
    stall = 1'b1;
    set_req(2, 1'b0, 9, '0);
    wait_ready(30, cyc, rdy, rd, er);
    vec++; if (cyc !== TO + 2) begin bad++; $display("FAIL to_latency: got %0d want %0d", cyc, TO + 2); end
    vec++; if (rdy !== 4'b0100) begin bad++; $display("FAIL to_ready: got %b want 0100", rdy); end
    vec++; if (er !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", er); end
    vec++; if (rd !== '0) begin bad++; $display("FAIL to_data: got %h want 0", rd); end
    model_commit(2); clr_req(2); stall = 1'b0; @(negedge clk);
    d = W'($urandom);
    set_req(3, 1'b1, 9, d);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if ({cyc, rdy, er} !== {32'd3, 4'b1000, 1'b0}) begin bad++; $display("FAIL after_to: got cyc %0d rdy %b err %b want 3 1000 0", cyc, rdy, er); end
    model_commit(3); clr_req(3); @(negedge clk);
    set_req(3, 1'b0, 9, '0);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (rd !== d) begin bad++; $display("FAIL after_to_read: got %h want %h", rd, d); end
    model_commit(3); clr_req(3); @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int cyc; logic [N-1:0] rdy; logic [W-1:0] rd; logic er;
    set_req(0, 1'b1, 5, 16'hBEEF);
    wait_ready(10, cyc, rdy, rd, er);
    model_commit(0); clr_req(0); @(negedge clk);
    set_req(1, 1'b0, 5, '0);
    repeat (2) @(negedge clk);
    vec++; if (bus.mem_addr_o !== AW'(5)) begin bad++; $display("FAIL wait_addr: got %0d want 5", bus.mem_addr_o); end
    rst = 1'b1; clr_req(1);
    @(negedge clk);
    vec++; if ({bus.req_ready_o, bus.rdata_o, bus.err_o, bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", {bus.req_ready_o, bus.rdata_o, bus.err_o, bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o}); end
    rst = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    repeat (4) begin
      @(negedge clk);
      vec++; if (bus.req_ready_o !== '0) begin bad++; $display("FAIL midreset_no_pulse: got %b want 0000", bus.req_ready_o); end
    end
    set_req(0, 1'b0, 5, '0);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if ({cyc, rdy, rd, er} !== {32'd3, 4'b0001, 16'h0000, 1'b0}) begin bad++; $display("FAIL midreset_read: got cyc %0d rdy %b data %h err %b want 3 0001 0000 0", cyc, rdy, rd, er); end
    model_commit(0); clr_req(0); @(negedge clk);
  endtask
  task automatic test_top_addr();
    int cyc, v0; logic [N-1:0] rdy; logic [W-1:0] rd; logic er; logic [W-1:0] d;
    d = W'($urandom);
    v0 = vcnt;
    set_req(2, 1'b1, D - 1, d);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (rdy !== 4'b0100) begin bad++; $display("FAIL top_wr_ready: got %b want 0100", rdy); end
    vec++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL top_wr_valid_cycles: got %0d want 1", vcnt - v0); end
    model_commit(2); clr_req(2); @(negedge clk);
    v0 = vcnt;
    set_req(2, 1'b0, D - 1, '0);
    wait_ready(10, cyc, rdy, rd, er);
    vec++; if (rd !== d) begin bad++; $display("FAIL top_rd_data: got %h want %h", rd, d); end
    vec++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL top_rd_valid_cycles: got %0d want 1", vcnt - v0); end
    model_commit(2); clr_req(2); @(negedge clk);
  endtask
  task automatic test_random();
    int cyc, v0, k, guard; bit first; logic [N-1:0] rdy, mask; logic [W-1:0] rd, e; logic er;
    for (int r = 0; r < 30; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < N; j++) if (mask[j]) set_req(j, 1'($urandom), int'($urandom_range(0, 7)), W'($urandom));
      first = 1'b1;
      guard = 0;
      while (pend != '0 && guard < 12) begin
        guard++;
        v0 = vcnt;
        k = model_pick();
        e = model_resp(k);
        wait_ready(20, cyc, rdy, rd, er);
        vec++; if (rdy !== 4'(1 << k)) begin bad++; $display("FAIL rnd_grant r%0d: got %b want %b", r, rdy, 4'(1 << k)); end
        vec++; if ({er, rd} !== {1'b0, e}) begin bad++; $display("FAIL rnd_data r%0d: got err %b data %h want 0 %h", r, er, rd, e); end
        vec++; if (cyc !== (first ? 3 : 4)) begin bad++; $display("FAIL rnd_latency r%0d: got %0d want %0d", r, cyc, first ? 3 : 4); end
        vec++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL rnd_valid_cycles r%0d: got %0d want 1", r, vcnt - v0); end
        first = 1'b0;
        model_commit(k);
        clr_req(k);
        if ($urandom_range(0, 3) == 0) set_req(k, 1'($urandom), int'($urandom_range(0, 7)), W'($urandom));
      end
      for (int j = 0; j < N; j++) clr_req(j);
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_write_read();
    test_all_four();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_top_addr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
